pixel_to_tile: RTL and testbench

PIXEL_TO_TILE -- requirements
Module: pixel_to_tile

---
 rtl/pixel_to_tile_pkg.sv | 20 ++
 rtl/pixel_to_tile_line_ram.sv | 25 ++
 rtl/pixel_to_tile.sv | 135 +++++++++++++
 tb/tb_pixel_to_tile.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_to_tile_pkg.sv
// Shared video definitions for the raster-to-column tiler: FSM encoding,
// pipeline depth and the counter-width helper.
package pixel_to_tile_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // Register stages between the accepting edge and the output registers
  localparam int STAGES = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pixel_to_tile_line_ram.sv
// Simple dual-port line buffer: one write port, one read port with a
// registered (1-cycle) read.
module pixel_to_tile_line_ram
  import pixel_to_tile_pkg::*;
#(
  parameter int DEPTH = 1280,
  parameter int DW    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]           i_wdata,
  input  logic                    i_re,
  input  logic [clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]           o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/pixel_to_tile.sv
// Buffers BLOCK_ROWS-1 raster lines and, while the last row of each group
// streams in, emits vertical columns of BLOCK_ROWS pixels.
module pixel_to_tile
  import pixel_to_tile_pkg::*;
#(
  parameter int LINE_SIZE  = 1280,
  parameter int BLOCK_ROWS = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic                             wr_in_en,
  input  logic [DATA_WIDTH-1:0]            pixel,
  output logic                             wr_out_en,
  output logic [BLOCK_ROWS*DATA_WIDTH-1:0] pixel_col,
  output logic [clog2(LINE_SIZE)-1:0]      col_idx,
  output logic                             group_last,
  output logic [15:0]                      group_idx
);

  localparam int CW = clog2(LINE_SIZE);
  localparam int RW = clog2(BLOCK_ROWS);
  localparam int NL = BLOCK_ROWS - 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(LINE_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(BLOCK_ROWS - 1);
  localparam logic [RW-1:0] ROW_PRE   = RW'(BLOCK_ROWS - 2);

  state_t        r_state, w_state_cur, w_state_nxt;
  logic [CW-1:0] r_wr_col, w_col_cur, w_col_nxt;
  logic [RW-1:0] r_row, w_row_cur, w_row_nxt;
  logic          w_line_end, w_fill, w_emit;

  // frame_start rewinds position and state before the same-cycle pixel is
  // considered, so that pixel lands as row 0 / col 0 of the new frame.
  always_comb begin
    w_col_cur   = frame_start ? '0 : r_wr_col;
    w_row_cur   = frame_start ? '0 : r_row;
    w_state_cur = frame_start ? S_FILL : r_state;
    w_line_end  = (w_col_cur == COL_LAST);
    w_fill      = wr_in_en && (w_state_cur == S_FILL);
    w_emit      = wr_in_en && (w_state_cur == S_EMIT);
    w_col_nxt   = w_col_cur;
    w_row_nxt   = w_row_cur;
    w_state_nxt = w_state_cur;
    if (wr_in_en) begin
      w_col_nxt = w_line_end ? '0 : w_col_cur + CW'(1);
      if (w_line_end) w_row_nxt = (w_row_cur == ROW_LAST) ? '0 : w_row_cur + RW'(1);
    end
    case (w_state_cur)
      S_FILL:  if (wr_in_en && w_line_end && (w_row_cur == ROW_PRE)) w_state_nxt = S_EMIT;
      S_EMIT:  if (wr_in_en && w_line_end) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state  <= S_FILL;
      r_wr_col <= '0;
      r_row    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_col <= w_col_nxt;
      r_row    <= w_row_nxt;
    end
  end

  logic [NL-1:0][DATA_WIDTH-1:0] w_rd;

  // Line k holds row k of the group; reads only happen in S_EMIT, writes
  // only in S_FILL, so the two ports never collide.
  for (genvar k = 0; k < NL; k++) begin : g_line
    pixel_to_tile_line_ram #(
      .DEPTH(LINE_SIZE),
      .DW   (DATA_WIDTH)
    ) u_ram (
      .i_clk  (pclk),
      .i_we   (w_fill && (w_row_cur == RW'(k))),
      .i_waddr(w_col_cur),
      .i_wdata(pixel),
      .i_re   (w_emit),
      .i_raddr(w_col_cur),
      .o_rdata(w_rd[k])
    );
  end

  logic [STAGES:0]                       r_vld_pipe;
  logic [DATA_WIDTH-1:0]                 r_pix_s0;
  logic [CW-1:0]                         r_col_s0, r_col_s1, r_col_out;
  logic                                  r_last_s0, r_last_s1, r_last_out;
  logic [BLOCK_ROWS-1:0][DATA_WIDTH-1:0] r_word_s1, r_word_out;
  logic [15:0]                           r_gidx;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_word_out <= '0;
      r_col_out  <= '0;
      r_last_out <= 1'b0;
      r_gidx     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_emit};
      if (r_vld_pipe[1]) begin
        r_word_out <= r_word_s1;
        r_col_out  <= r_col_s1;
        r_last_out <= r_last_s1;
      end
      if (frame_start)                     r_gidx <= '0;
      else if (r_vld_pipe[1] && r_last_s1) r_gidx <= r_gidx + 16'd1;
    end
  end

  // Datapath stages carry no reset; the valid pipe alone qualifies them.
  always_ff @(posedge pclk) begin
    if (w_emit) begin
      r_pix_s0  <= pixel;
      r_col_s0  <= w_col_cur;
      r_last_s0 <= w_line_end;
    end
    if (r_vld_pipe[0]) begin
      r_word_s1[0] <= r_pix_s0;
      for (int k = 0; k < NL; k++) r_word_s1[BLOCK_ROWS-1-k] <= w_rd[k];
      r_col_s1  <= r_col_s0;
      r_last_s1 <= r_last_s0;
    end
  end

  assign wr_out_en  = r_vld_pipe[STAGES];
  assign pixel_col  = r_word_out;
  assign col_idx    = r_col_out;
  assign group_last = r_last_out;
  assign group_idx  = r_gidx;

endmodule

// File: tb/tb_pixel_to_tile.sv
// Directed bench for pixel_to_tile: 8-pixel lines, pixel = row*16+col (+offset).
module tb_pixel_to_tile;

  localparam int LS = 8;

  logic        pclk = 1'b0;
  logic        rst, frame_start, wr_in_en;
  logic [15:0] pixel;

  logic        wr_out_en, group_last;
  logic [63:0] pixel_col;
  logic [2:0]  col_idx;
  logic [15:0] group_idx;

  logic        a_en, a_last, b_en, b_last;
  logic [15:0] a_col;
  logic [63:0] b_col;
  logic [2:0]  a_idx, b_idx;
  logic [15:0] a_gi, b_gi;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  int edge_n = 0;
  always @(posedge pclk) edge_n <= edge_n + 1;

  pixel_to_tile #(.LINE_SIZE(LS), .BLOCK_ROWS(4), .DATA_WIDTH(16)) u_dut (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .wr_in_en(wr_in_en),
    .pixel(pixel), .wr_out_en(wr_out_en), .pixel_col(pixel_col),
    .col_idx(col_idx), .group_last(group_last), .group_idx(group_idx));

  pixel_to_tile #(.LINE_SIZE(LS), .BLOCK_ROWS(2), .DATA_WIDTH(8)) u_n2 (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .wr_in_en(wr_in_en),
    .pixel(pixel[7:0]), .wr_out_en(a_en), .pixel_col(a_col),
    .col_idx(a_idx), .group_last(a_last), .group_idx(a_gi));

  pixel_to_tile #(.LINE_SIZE(LS), .BLOCK_ROWS(8), .DATA_WIDTH(8)) u_n8 (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .wr_in_en(wr_in_en),
    .pixel(pixel[7:0]), .wr_out_en(b_en), .pixel_col(b_col),
    .col_idx(b_idx), .group_last(b_last), .group_idx(b_gi));

  // Output capture: every strobe is logged with the edge that produced it
  int          m_n = 0, a_n = 0, b_n = 0;
  logic [63:0] m_word [256];
  int          m_edge [256];
  logic [2:0]  m_idx  [256];
  logic        m_last [256];
  logic [15:0] m_gi   [256];
  logic [15:0] a_word [256];
  int          a_edge [256];
  logic [63:0] b_word [256];
  int          b_edge [256];

  always @(negedge pclk) begin
    if (wr_out_en === 1'b1 && m_n < 256) begin
      m_word[m_n] = pixel_col; m_edge[m_n] = edge_n; m_idx[m_n] = col_idx;
      m_last[m_n] = group_last; m_gi[m_n] = group_idx; m_n = m_n + 1;
    end
    if (a_en === 1'b1 && a_n < 256) begin
      a_word[a_n] = a_col; a_edge[a_n] = edge_n; a_n = a_n + 1;
    end
    if (b_en === 1'b1 && b_n < 256) begin
      b_word[b_n] = b_col; b_edge[b_n] = edge_n; b_n = b_n + 1;
    end
  end

  int acc [16][LS];

  task automatic drive(input logic fs, input logic en, input logic [15:0] px);
    @(negedge pclk);
    frame_start = fs; wr_in_en = en; pixel = px;
  endtask

  task automatic send(input logic fs, input int row, input int col, input int off);
    drive(fs, 1'b1, 16'(off + row * 16 + col));
    acc[row][col] = edge_n + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'hdead);
  endtask

  task automatic lines(input int r0, input int r1, input bit gap, input int off);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < LS; c++) begin
        send(1'b0, r, c, off);
        if (gap) idle(1);
      end
  endtask

  function automatic logic [63:0] exp4(input int r0, input int c, input int off);
    return {16'(off + r0 * 16 + c), 16'(off + (r0 + 1) * 16 + c),
            16'(off + (r0 + 2) * 16 + c), 16'(off + (r0 + 3) * 16 + c)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; wr_in_en = 1'b1; pixel = 16'h1234;
    repeat (3) @(negedge pclk);
    wr_in_en = 1'b0;
    checks++; if (wr_out_en !== 1'b0) begin errors++; $display("FAIL reset_wr_out_en got %b exp 0", wr_out_en); end
    checks++; if (pixel_col !== 64'h0) begin errors++; $display("FAIL reset_pixel_col got %h exp 0", pixel_col); end
    checks++; if (col_idx !== 3'd0) begin errors++; $display("FAIL reset_col_idx got %0d exp 0", col_idx); end
    checks++; if (group_last !== 1'b0) begin errors++; $display("FAIL reset_group_last got %b exp 0", group_last); end
    checks++; if (group_idx !== 16'd0) begin errors++; $display("FAIL reset_group_idx got %0d exp 0", group_idx); end
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    int s, n;
    s = m_n;
    drive(1'b1, 1'b0, 16'h0);
    lines(0, 7, 1'b0, 0);
    idle(4);
    n = m_n - s;
    checks++; if (n !== 16) begin errors++; $display("FAIL cont_count got %0d exp 16", n); end
    for (int k = 0; k < n && k < 16; k++) begin
      int g, c;
      g = k / 8; c = k % 8;
      checks++; if (m_word[s+k] !== exp4(4*g, c, 0)) begin errors++; $display("FAIL cont_word[%0d] got %h exp %h", k, m_word[s+k], exp4(4*g, c, 0)); end
      checks++; if (m_idx[s+k] !== 3'(c)) begin errors++; $display("FAIL cont_idx[%0d] got %0d exp %0d", k, m_idx[s+k], c); end
      checks++; if (m_last[s+k] !== (c == 7)) begin errors++; $display("FAIL cont_last[%0d] got %b exp %b", k, m_last[s+k], c == 7); end
      checks++; if (m_edge[s+k] !== acc[4*g+3][c] + 2) begin errors++; $display("FAIL cont_latency[%0d] got %0d exp %0d", k, m_edge[s+k], acc[4*g+3][c] + 2); end
    end
    if (n >= 8) begin
      checks++; if (m_gi[s+7] !== 16'd1) begin errors++; $display("FAIL cont_gidx_first got %0d exp 1", m_gi[s+7]); end
    end
    checks++; if (group_idx !== 16'd2) begin errors++; $display("FAIL cont_gidx_end got %0d exp 2", group_idx); end
  endtask

  task automatic test_gaps();
    int s, n;
    s = m_n;
    drive(1'b1, 1'b0, 16'h0);
    lines(0, 3, 1'b1, 0);
    idle(4);
    n = m_n - s;
    checks++; if (n !== 8) begin errors++; $display("FAIL gap_count got %0d exp 8", n); end
    for (int c = 0; c < n && c < 8; c++) begin
      checks++; if (m_word[s+c] !== exp4(0, c, 0)) begin errors++; $display("FAIL gap_word[%0d] got %h exp %h", c, m_word[s+c], exp4(0, c, 0)); end
      checks++; if (m_edge[s+c] !== acc[3][c] + 2) begin errors++; $display("FAIL gap_latency[%0d] got %0d exp %0d", c, m_edge[s+c], acc[3][c] + 2); end
    end
    checks++; if (group_idx !== 16'd1) begin errors++; $display("FAIL gap_gidx got %0d exp 1", group_idx); end
  endtask

  task automatic test_frame_restart();
    int s, n;
    s = m_n;
    drive(1'b1, 1'b0, 16'h0);
    lines(0, 1, 1'b0, 'h800);
    for (int c = 0; c < 3; c++) send(1'b0, 2, c, 'h800);
    send(1'b1, 0, 0, 0);
    for (int c = 1; c < LS; c++) send(1'b0, 0, c, 0);
    lines(1, 3, 1'b0, 0);
    idle(4);
    n = m_n - s;
    checks++; if (n !== 8) begin errors++; $display("FAIL restart_count got %0d exp 8", n); end
    for (int c = 0; c < n && c < 8; c++) begin
      checks++; if (m_word[s+c] !== exp4(0, c, 0)) begin errors++; $display("FAIL restart_word[%0d] got %h exp %h", c, m_word[s+c], exp4(0, c, 0)); end
      checks++; if (m_edge[s+c] !== acc[3][c] + 2) begin errors++; $display("FAIL restart_latency[%0d] got %0d exp %0d", c, m_edge[s+c], acc[3][c] + 2); end
    end
    checks++; if (group_idx !== 16'd1) begin errors++; $display("FAIL restart_gidx got %0d exp 1", group_idx); end
  endtask

  task automatic test_reset_midline();
    int s, n;
    s = m_n;
    drive(1'b1, 1'b0, 16'h0);
    lines(0, 2, 1'b0, 0);
    for (int c = 0; c < 6; c++) send(1'b0, 3, c, 0);
    @(negedge pclk);
    rst = 1'b1; wr_in_en = 1'b0; frame_start = 1'b0;
    @(negedge pclk);
    checks++; if (wr_out_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_out_en got %b exp 0", wr_out_en); end
    checks++; if (pixel_col !== 64'h0) begin errors++; $display("FAIL rstmid_pixel_col got %h exp 0", pixel_col); end
    checks++; if (col_idx !== 3'd0) begin errors++; $display("FAIL rstmid_col_idx got %0d exp 0", col_idx); end
    rst = 1'b0;
    idle(3);
    n = m_n - s;
    checks++; if (n !== 4) begin errors++; $display("FAIL rstmid_count got %0d exp 4", n); end
    for (int c = 0; c < n && c < 4; c++) begin
      checks++; if (m_word[s+c] !== exp4(0, c, 0)) begin errors++; $display("FAIL rstmid_word[%0d] got %h exp %h", c, m_word[s+c], exp4(0, c, 0)); end
    end
    s = m_n;
    lines(0, 3, 1'b0, 'h200);
    idle(4);
    n = m_n - s;
    checks++; if (n !== 8) begin errors++; $display("FAIL rstmid_next_count got %0d exp 8", n); end
    for (int c = 0; c < n && c < 8; c++) begin
      checks++; if (m_word[s+c] !== exp4(0, c, 'h200)) begin errors++; $display("FAIL rstmid_next_word[%0d] got %h exp %h", c, m_word[s+c], exp4(0, c, 'h200)); end
    end
  endtask

  task automatic test_back_to_back();
    int s, n, e_last;
    s = m_n;
    drive(1'b1, 1'b0, 16'h0);
    lines(0, 3, 1'b0, 0);
    e_last = acc[3][7];
    send(1'b1, 0, 0, 'h100);
    for (int c = 1; c < LS; c++) send(1'b0, 0, c, 'h100);
    lines(1, 3, 1'b0, 'h100);
    idle(4);
    n = m_n - s;
    checks++; if (n !== 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", n); end
    if (n >= 8) begin
      checks++; if (m_word[s+7] !== exp4(0, 7, 0)) begin errors++; $display("FAIL b2b_tail_word got %h exp %h", m_word[s+7], exp4(0, 7, 0)); end
      checks++; if (m_edge[s+7] !== e_last + 2) begin errors++; $display("FAIL b2b_tail_latency got %0d exp %0d", m_edge[s+7], e_last + 2); end
      checks++; if (m_last[s+7] !== 1'b1) begin errors++; $display("FAIL b2b_tail_last got %b exp 1", m_last[s+7]); end
    end
    for (int c = 0; c + 8 < n && c < 8; c++) begin
      checks++; if (m_word[s+8+c] !== exp4(0, c, 'h100)) begin errors++; $display("FAIL b2b_new_word[%0d] got %h exp %h", c, m_word[s+8+c], exp4(0, c, 'h100)); end
    end
  endtask

  task automatic test_param_sweep();
    int sa, sb, na, nb;
    @(negedge pclk);
    rst = 1'b1; wr_in_en = 1'b0; frame_start = 1'b0;
    @(negedge pclk);
    rst = 1'b0;
    sa = a_n; sb = b_n;
    lines(0, 7, 1'b0, 0);
    idle(4);
    na = a_n - sa; nb = b_n - sb;
    checks++; if (na !== 32) begin errors++; $display("FAIL n2_count got %0d exp 32", na); end
    for (int k = 0; k < na && k < 32; k++) begin
      int r0, c;
      logic [15:0] e2;
      r0 = 2 * (k / 8); c = k % 8;
      e2 = {8'(r0 * 16 + c), 8'((r0 + 1) * 16 + c)};
      checks++; if (a_word[sa+k] !== e2) begin errors++; $display("FAIL n2_word[%0d] got %h exp %h", k, a_word[sa+k], e2); end
      checks++; if (a_edge[sa+k] !== acc[r0+1][c] + 2) begin errors++; $display("FAIL n2_latency[%0d] got %0d exp %0d", k, a_edge[sa+k], acc[r0+1][c] + 2); end
    end
    checks++; if (nb !== 8) begin errors++; $display("FAIL n8_count got %0d exp 8", nb); end
    for (int c = 0; c < nb && c < 8; c++) begin
      logic [63:0] e8;
      e8 = '0;
      for (int r = 0; r < 8; r++) e8[(7-r)*8 +: 8] = 8'(r * 16 + c);
      checks++; if (b_word[sb+c] !== e8) begin errors++; $display("FAIL n8_word[%0d] got %h exp %h", c, b_word[sb+c], e8); end
      checks++; if (b_edge[sb+c] !== acc[7][c] + 2) begin errors++; $display("FAIL n8_latency[%0d] got %0d exp %0d", c, b_edge[sb+c], acc[7][c] + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_frame_restart();
    test_reset_midline();
    test_back_to_back();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
